// File: rtl/instr_queue.sv
// Dual-issue instruction queue between fetch and decode: a circular buffer of
// {instr, pc} entries that accepts up to two fetched instructions per cycle and presents the two oldest.
module instr_queue #(
  parameter int unsigned WORD  = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid1,
  input  logic                    in_valid2,
  input  logic [0:WORD-1]         in_instr1,
  input  logic [0:WORD-1]         in_instr2,
  input  logic [0:WORD-1]         in_pc,
  output logic                    in_ready,
  output logic [0:WORD-1]         out_instr1,
  output logic [0:WORD-1]         out_instr2,
  output logic [0:WORD-1]         out_pc1,
  output logic [0:WORD-1]         out_pc2,
  output logic                    out_valid1,
  output logic                    out_valid2,
  input  logic [0:1]              issue_cnt,
  output logic [0:$clog2(DEPTH)]  count,
  output logic                    issue_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [0:WORD-1] mem_instr [DEPTH];
  logic [0:WORD-1] mem_pc    [DEPTH];

  logic [0:AW-1] rd_ptr, wr_ptr, rd_ptr_nx1, wr_ptr_nx1;
  logic [0:1]    n_wr, n_req, n_iss;
  logic          wr_en, over_issue;
  logic [0:WORD-1] pc2;

  always_comb begin
    in_ready   = (count <= CW'(DEPTH - 2));
    wr_en      = in_ready & (in_valid1 | in_valid2) & ~flush;
    n_wr       = wr_en ? ({1'b0, in_valid1} + {1'b0, in_valid2}) : '0;
    n_req      = (issue_cnt == 2'd3) ? 2'd2 : issue_cnt;
    // An over-request can only happen with count < 2, so its low two bits are the clamp.
    n_iss      = (CW'(n_req) > count) ? count[CW-2:CW-1] : n_req;
    over_issue = (issue_cnt == 2'd3) | (CW'(issue_cnt) > count);
    pc2        = in_pc + WORD'(4);
    rd_ptr_nx1 = rd_ptr + AW'(1);
    wr_ptr_nx1 = wr_ptr + AW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      issue_err <= 1'b0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(n_iss);
      wr_ptr <= wr_ptr + AW'(n_wr);
      count  <= count + CW'(n_wr) - CW'(n_iss);
      if (over_issue) issue_err <= 1'b1;
    end
  end

  // Entry storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (in_valid1) begin
        mem_instr[wr_ptr] <= in_instr1;
        mem_pc[wr_ptr]    <= in_pc;
        if (in_valid2) begin
          mem_instr[wr_ptr_nx1] <= in_instr2;
          mem_pc[wr_ptr_nx1]    <= pc2;
        end
      end else begin
        mem_instr[wr_ptr] <= in_instr2;
        mem_pc[wr_ptr]    <= pc2;
      end
    end
  end

  always_comb begin
    out_valid1 = (count >= CW'(1));
    out_valid2 = (count >= CW'(2));
    out_instr1 = mem_instr[rd_ptr];
    out_pc1    = mem_pc[rd_ptr];
    out_instr2 = mem_instr[rd_ptr_nx1];
    out_pc2    = mem_pc[rd_ptr_nx1];
  end

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: the driver queues hand-computed expectations,
// a monitor pops and compares one per cycle shortly after each rising edge.
module tb_instr_queue;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid1, in_valid2;
  logic [0:31] in_instr1, in_instr2, in_pc;
  logic        in_ready, out_valid1, out_valid2, issue_err;
  logic [0:31] out_instr1, out_instr2, out_pc1, out_pc2;
  logic [0:1]  issue_cnt;
  logic [0:3]  count;

  instr_queue #(.WORD(32), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid1(in_valid1), .in_valid2(in_valid2),
    .in_instr1(in_instr1), .in_instr2(in_instr2), .in_pc(in_pc),
    .in_ready(in_ready),
    .out_instr1(out_instr1), .out_instr2(out_instr2),
    .out_pc1(out_pc1), .out_pc2(out_pc2),
    .out_valid1(out_valid1), .out_valid2(out_valid2),
    .issue_cnt(issue_cnt), .count(count), .issue_err(issue_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          cnt;
    logic        err;
    logic [31:0] p1, i1, p2, i2;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: compares the state presented after each rising edge.
  always @(posedge clk) begin
    #2;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.name, ".count"},  32'(count), 32'(e.cnt));
      chk({e.name, ".valid1"}, 32'(out_valid1), 32'(e.cnt >= 1));
      chk({e.name, ".valid2"}, 32'(out_valid2), 32'(e.cnt >= 2));
      chk({e.name, ".ready"},  32'(in_ready), 32'(e.cnt <= 6));
      chk({e.name, ".err"},    32'(issue_err), 32'(e.err));
      if (e.cnt >= 1) begin
        chk({e.name, ".pc1"},    out_pc1, e.p1);
        chk({e.name, ".instr1"}, out_instr1, e.i1);
      end
      if (e.cnt >= 2) begin
        chk({e.name, ".pc2"},    out_pc2, e.p2);
        chk({e.name, ".instr2"}, out_instr2, e.i2);
      end
    end
  end

  // Drive one cycle of inputs on the falling edge and queue the expected post-edge state.
  task automatic cyc(input logic v1, input logic v2, input logic [31:0] pc,
                     input logic [31:0] i1, input logic [31:0] i2,
                     input logic [1:0] iss, input logic fl,
                     input string nm, input int c, input logic e,
                     input logic [31:0] ep1, input logic [31:0] ei1,
                     input logic [31:0] ep2, input logic [31:0] ei2);
    exp_t x;
    @(negedge clk);
    in_valid1 = v1; in_valid2 = v2; in_pc = pc;
    in_instr1 = i1; in_instr2 = i2; issue_cnt = iss; flush = fl;
    x.name = nm; x.cnt = c; x.err = e;
    x.p1 = ep1; x.i1 = ei1; x.p2 = ep2; x.i2 = ei2;
    sb.push_back(x);
  endtask

  task automatic idle(input logic [1:0] iss, input logic fl, input string nm,
                      input int c, input logic e,
                      input logic [31:0] ep1, input logic [31:0] ei1,
                      input logic [31:0] ep2, input logic [31:0] ei2);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, iss, fl, nm, c, e, ep1, ei1, ep2, ei2);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0;
    in_pc = '0; in_instr1 = '0; in_instr2 = '0; issue_cnt = '0;

    idle(2'd0, 1'b0, "reset", 0, 1'b0, 0, 0, 0, 0);
    idle(2'd0, 1'b0, "reset2", 0, 1'b0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    sb.push_back('{name: "release", cnt: 0, err: 1'b0, p1: 0, i1: 0, p2: 0, i2: 0});

    // First write right after release, then a lone second slot.
    cyc(1, 1, 32'h100, 32'hA, 32'hB, 2'd0, 0, "pair", 2, 0, 32'h100, 32'hA, 32'h104, 32'hB);
    idle(2'd2, 0, "drain_pair", 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h204, 32'h0, 32'hC, 2'd0, 0, "v2only", 1, 0, 32'h208, 32'hC, 0, 0);
    idle(2'd1, 0, "drain_v2", 0, 0, 0, 0, 0, 0);

    // Fill from pointer 3 so the buffer wraps, then drain in order.
    cyc(1, 1, 32'h1000, 32'h10, 32'h11, 2'd0, 0, "fill1", 2, 0, 32'h1000, 32'h10, 32'h1004, 32'h11);
    cyc(1, 1, 32'h1008, 32'h12, 32'h13, 2'd0, 0, "fill2", 4, 0, 32'h1000, 32'h10, 32'h1004, 32'h11);
    cyc(1, 1, 32'h1010, 32'h14, 32'h15, 2'd0, 0, "fill3", 6, 0, 32'h1000, 32'h10, 32'h1004, 32'h11);
    cyc(1, 1, 32'h1018, 32'h16, 32'h17, 2'd0, 0, "fill4", 8, 0, 32'h1000, 32'h10, 32'h1004, 32'h11);
    cyc(1, 1, 32'h1020, 32'h18, 32'h19, 2'd0, 0, "full_drop", 8, 0, 32'h1000, 32'h10, 32'h1004, 32'h11);
    idle(2'd2, 0, "drain1", 6, 0, 32'h1008, 32'h12, 32'h100C, 32'h13);
    idle(2'd2, 0, "drain2", 4, 0, 32'h1010, 32'h14, 32'h1014, 32'h15);
    idle(2'd2, 0, "drain3", 2, 0, 32'h1018, 32'h16, 32'h101C, 32'h17);
    idle(2'd2, 0, "drain4", 0, 0, 0, 0, 0, 0);

    // Concurrent write and issue.
    cyc(1, 1, 32'h2000, 32'h20, 32'h21, 2'd0, 0, "wi1", 2, 0, 32'h2000, 32'h20, 32'h2004, 32'h21);
    cyc(1, 1, 32'h2008, 32'h22, 32'h23, 2'd0, 0, "wi2", 4, 0, 32'h2000, 32'h20, 32'h2004, 32'h21);
    cyc(1, 1, 32'h2010, 32'h24, 32'h25, 2'd1, 0, "wr_iss", 5, 0, 32'h2004, 32'h21, 32'h2008, 32'h22);

    // Flush beats a same-cycle write and issue.
    cyc(1, 0, 32'h3000, 32'h30, 32'h0, 2'd2, 1, "flush", 0, 0, 0, 0, 0, 0);
    idle(2'd0, 0, "post_flush", 0, 0, 0, 0, 0, 0);

    // Single write brings count to 7; in_ready must already be low.
    cyc(1, 1, 32'h4000, 32'h40, 32'h41, 2'd0, 0, "f7a", 2, 0, 32'h4000, 32'h40, 32'h4004, 32'h41);
    cyc(1, 1, 32'h4008, 32'h42, 32'h43, 2'd0, 0, "f7b", 4, 0, 32'h4000, 32'h40, 32'h4004, 32'h41);
    cyc(1, 1, 32'h4010, 32'h44, 32'h45, 2'd0, 0, "f7c", 6, 0, 32'h4000, 32'h40, 32'h4004, 32'h41);
    cyc(1, 0, 32'h4018, 32'h46, 32'h0,  2'd0, 0, "cnt7", 7, 0, 32'h4000, 32'h40, 32'h4004, 32'h41);
    cyc(1, 1, 32'h4020, 32'h48, 32'h49, 2'd0, 0, "cnt7_drop", 7, 0, 32'h4000, 32'h40, 32'h4004, 32'h41);
    idle(2'd0, 1, "flush2", 0, 0, 0, 0, 0, 0);

    // Over-issue error is sticky across flush.
    cyc(1, 0, 32'h5000, 32'h50, 32'h0, 2'd0, 0, "one", 1, 0, 32'h5000, 32'h50, 0, 0);
    idle(2'd2, 0, "over_issue", 0, 1, 0, 0, 0, 0);
    idle(2'd0, 1, "err_flush", 0, 1, 0, 0, 0, 0);

    // PC wrap on the second slot, with issue_cnt=3 on an empty queue.
    cyc(1, 1, 32'hFFFF_FFFC, 32'h60, 32'h61, 2'd3, 0, "pc_wrap", 2, 1,
        32'hFFFF_FFFC, 32'h60, 32'h0000_0000, 32'h61);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    in_valid1 = 1'b0; in_valid2 = 1'b0; issue_cnt = '0; flush = 1'b0;
    reset = 1'b0;
    #1;
    chk("async_reset.count", 32'(count), 32'd0);
    chk("async_reset.err", 32'(issue_err), 32'd0);
    sb.push_back('{name: "in_reset", cnt: 0, err: 1'b0, p1: 0, i1: 0, p2: 0, i2: 0});
    @(negedge clk);
    reset = 1'b1;
    idle(2'd0, 0, "after_reset", 0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #4;
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain_scoreboard: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
